// File: rtl/glyph_blitter_if.sv
// Bus bundle between the game/keyboard logic and glyph_blitter.
// The master drives slot writes and start; the slave (glyph_blitter) drives the
// pixel stream towards vga_adapter together with busy/done status.
interface glyph_blitter_if #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned GLYPH_W   = 5,
    parameter int unsigned GLYPH_H   = 5,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COLOUR_W  = 3
);
    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                       wr_en;
    logic [SLOT_W-1:0]          wr_slot;
    logic [X_W-1:0]             wr_x;
    logic [Y_W-1:0]             wr_y;
    logic [GLYPH_W*GLYPH_H-1:0] wr_glyph;
    logic [COLOUR_W-1:0]        wr_fg;
    logic [COLOUR_W-1:0]        bg;
    logic                       start;
    logic                       full_redraw;
    logic [X_W-1:0]             x;
    logic [Y_W-1:0]             y;
    logic [COLOUR_W-1:0]        colour;
    logic                       plot;
    logic                       busy;
    logic                       done;

    modport master (
        output wr_en, wr_slot, wr_x, wr_y, wr_glyph, wr_fg, bg, start, full_redraw,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  wr_en, wr_slot, wr_x, wr_y, wr_glyph, wr_fg, bg, start, full_redraw,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/glyph_blitter.sv
// Glyph blitter: NUM_SLOTS glyph slots, each redrawn pixel-by-pixel into
// vga_adapter when dirty (or on a full redraw), one pixel per clock.
// Optional build macro GLYPH_BORDER_EN adds a one-pixel BORDER_COLOUR ring
// around every drawn glyph box.
module glyph_blitter #(
    parameter int unsigned          NUM_SLOTS     = 4,
    parameter int unsigned          GLYPH_W       = 5,
    parameter int unsigned          GLYPH_H       = 5,
    parameter int unsigned          X_W           = 8,
    parameter int unsigned          Y_W           = 7,
    parameter int unsigned          COLOUR_W      = 3,
    parameter int unsigned          X_MAX         = 160,
    parameter int unsigned          Y_MAX         = 120,
    parameter logic [COLOUR_W-1:0]  BORDER_COLOUR = 3'b111
) (
    input logic            clk,
    input logic            reset,
    glyph_blitter_if.slave bus
);
    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned BITS   = GLYPH_W * GLYPH_H;
`ifdef GLYPH_BORDER_EN
    localparam int unsigned BOX_W  = GLYPH_W + 2;
    localparam int unsigned BOX_H  = GLYPH_H + 2;
`else
    localparam int unsigned BOX_W  = GLYPH_W;
    localparam int unsigned BOX_H  = GLYPH_H;
`endif
    localparam int unsigned COL_W  = $clog2(BOX_W + 1);
    localparam int unsigned ROW_W  = $clog2(BOX_H + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BOX_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(BOX_H - 1);
    localparam logic [SLOT_W-1:0] IDX_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [X_W:0]      X_LIMIT  = (X_W + 1)'(X_MAX);
    localparam logic [Y_W:0]      Y_LIMIT  = (Y_W + 1)'(Y_MAX);

    typedef enum logic [1:0] {StIdle, StSeek, StDraw, StFinish} state_e;

    // Slot storage
    logic [X_W-1:0]      r_slot_x     [NUM_SLOTS];
    logic [Y_W-1:0]      r_slot_y     [NUM_SLOTS];
    logic [BITS-1:0]     r_slot_glyph [NUM_SLOTS];
    logic [COLOUR_W-1:0] r_slot_fg    [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] r_dirty;
    logic [NUM_SLOTS-1:0] w_dirty_next;

    // Pass control and draw latch
    state_e              r_state;
    state_e              w_state_next;
    logic [SLOT_W-1:0]   r_idx;
    logic                r_full;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [X_W-1:0]      r_lat_x;
    logic [Y_W-1:0]      r_lat_y;
    logic [BITS-1:0]     r_lat_glyph;
    logic [COLOUR_W-1:0] r_lat_fg;

    // Registered pixel outputs
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;
    logic                r_busy;
    logic                r_done;

    logic                w_wr_hit;
    logic                w_seek_take;
    logic                w_last_idx;
    logic                w_last_pix;
    logic                w_interior;
    logic                w_under;
    logic                w_clip;
    logic [X_W:0]        w_px;
    logic [Y_W:0]        w_py;
    logic [COLOUR_W-1:0] w_pix_colour;

    assign w_wr_hit    = bus.wr_en && (int'(bus.wr_slot) < int'(NUM_SLOTS));
    assign w_seek_take = (r_state == StSeek) && (r_dirty[r_idx] || r_full);
    assign w_last_idx  = (r_idx == IDX_LAST);
    assign w_last_pix  = (r_col == COL_LAST) && (r_row == ROW_LAST);

    // Pixel coordinate, colour and clip decision for the current DRAW cycle.
    // The glyph latch shifts left per interior pixel, so its MSB is always the
    // bit for the pixel being drawn.
    always_comb begin
`ifdef GLYPH_BORDER_EN
        w_interior = !((r_col == '0) || (r_col == COL_LAST) ||
                       (r_row == '0) || (r_row == ROW_LAST));
        w_px       = {1'b0, r_lat_x} + (X_W + 1)'(r_col) - (X_W + 1)'(1);
        w_py       = {1'b0, r_lat_y} + (Y_W + 1)'(r_row) - (Y_W + 1)'(1);
        w_under    = ((r_lat_x == '0) && (r_col == '0)) || ((r_lat_y == '0) && (r_row == '0));
        if (!w_interior) begin
            w_pix_colour = BORDER_COLOUR;
        end else begin
            w_pix_colour = r_lat_glyph[BITS-1] ? r_lat_fg : bus.bg;
        end
`else
        w_interior   = 1'b1;
        w_px         = {1'b0, r_lat_x} + (X_W + 1)'(r_col);
        w_py         = {1'b0, r_lat_y} + (Y_W + 1)'(r_row);
        w_under      = 1'b0;
        w_pix_colour = r_lat_glyph[BITS-1] ? r_lat_fg : bus.bg;
`endif
        w_clip = w_under || (w_px >= X_LIMIT) || (w_py >= Y_LIMIT);
    end

`ifndef GLYPH_BORDER_EN
    logic [COLOUR_W-1:0] w_unused_border;
    assign w_unused_border = BORDER_COLOUR;
`endif

    // Slot field storage; out-of-range slot indices are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                r_slot_x[i]     <= '0;
                r_slot_y[i]     <= '0;
                r_slot_glyph[i] <= '0;
                r_slot_fg[i]    <= '0;
            end
        end else if (w_wr_hit) begin
            r_slot_x[bus.wr_slot]     <= bus.wr_x;
            r_slot_y[bus.wr_slot]     <= bus.wr_y;
            r_slot_glyph[bus.wr_slot] <= bus.wr_glyph;
            r_slot_fg[bus.wr_slot]    <= bus.wr_fg;
        end
    end

    // Dirty bits: SEEK clears the taken slot, a same-cycle write re-sets it.
    always_comb begin
        w_dirty_next = r_dirty;
        if (w_seek_take) begin
            w_dirty_next[r_idx] = 1'b0;
        end
        if (w_wr_hit) begin
            w_dirty_next[bus.wr_slot] = 1'b1;
        end
    end

    // Dirty bit register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= w_dirty_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_state_next = StSeek;
                end
            end
            StSeek: begin
                if (w_seek_take) begin
                    w_state_next = StDraw;
                end else if (w_last_idx) begin
                    w_state_next = StFinish;
                end
            end
            StDraw: begin
                if (w_last_pix) begin
                    w_state_next = w_last_idx ? StFinish : StSeek;
                end
            end
            StFinish: w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Slot index, pixel counters and draw latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_full      <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_lat_x     <= '0;
            r_lat_y     <= '0;
            r_lat_glyph <= '0;
            r_lat_fg    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_idx  <= '0;
                        r_full <= bus.full_redraw;
                    end
                end
                StSeek: begin
                    if (w_seek_take) begin
                        r_lat_x     <= r_slot_x[r_idx];
                        r_lat_y     <= r_slot_y[r_idx];
                        r_lat_glyph <= r_slot_glyph[r_idx];
                        r_lat_fg    <= r_slot_fg[r_idx];
                        r_col       <= '0;
                        r_row       <= '0;
                    end else if (!w_last_idx) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                StDraw: begin
                    if (w_interior) begin
                        r_lat_glyph <= r_lat_glyph << 1;
                    end
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    if (w_last_pix && !w_last_idx) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output registers: DRAW pixel appears one cycle later; busy tracks the
    // upcoming state so it drops together with the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot <= (r_state == StDraw) && !w_clip;
            if (r_state == StDraw) begin
                r_x      <= w_px[X_W-1:0];
                r_y      <= w_py[Y_W-1:0];
                r_colour <= w_pix_colour;
            end
            r_busy <= (w_state_next != StIdle);
            r_done <= (r_state == StFinish);
        end
    end

    assign bus.x      = r_x;
    assign bus.y      = r_y;
    assign bus.colour = r_colour;
    assign bus.plot   = r_plot;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: tb/tb_glyph_blitter.sv
// Directed bench for glyph_blitter with default parameters (4 slots, 5x5).
module tb_glyph_blitter;
    logic clk;
    logic reset;

    glyph_blitter_if bus_if ();

    glyph_blitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int         idx;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } vec_t;

    pix_t plots[$];
    int   busy_cycles;
    int   done_cnt;
    int   checks;
    int   errors;
    vec_t vecs[11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel/status monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.plot) plots.push_back('{bus_if.x, bus_if.y, bus_if.colour});
            if (bus_if.busy) busy_cycles++;
            if (bus_if.done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int s, input logic [7:0] wx, input logic [6:0] wy,
                              input logic [24:0] g, input logic [2:0] fg);
        bus_if.wr_en    = 1'b1;
        bus_if.wr_slot  = 2'(s);
        bus_if.wr_x     = wx;
        bus_if.wr_y     = wy;
        bus_if.wr_glyph = g;
        bus_if.wr_fg    = fg;
        tick();
        bus_if.wr_en    = 1'b0;
    endtask

    task automatic start_pass(input logic full);
        plots.delete();
        busy_cycles = 0;
        done_cnt    = 0;
        bus_if.start       = 1'b1;
        bus_if.full_redraw = full;
        tick();
        bus_if.start       = 1'b0;
        bus_if.full_redraw = 1'b0;
    endtask

    task automatic pulse_start();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (8) tick();
        check({name, "_done_pulses"}, done_cnt, 1);
    endtask

    task automatic wait_plots(input int cnt);
        int n;
        n = 0;
        while (plots.size() < cnt && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_plots_reached", (plots.size() >= cnt) ? 1 : 0, 1);
    endtask

    initial begin
        int bad;
        int offscreen;
        pix_t p;

        checks = 0;
        errors = 0;
        busy_cycles = 0;
        done_cnt = 0;

        // Expected pixels of the slot 2 "I" glyph at (10,20), fg 111, bg 000.
        vecs[0]  = '{0,  8'd10, 7'd20, 3'b000};
        vecs[1]  = '{1,  8'd11, 7'd20, 3'b111};
        vecs[2]  = '{3,  8'd13, 7'd20, 3'b111};
        vecs[3]  = '{4,  8'd14, 7'd20, 3'b000};
        vecs[4]  = '{5,  8'd10, 7'd21, 3'b000};
        vecs[5]  = '{7,  8'd12, 7'd21, 3'b111};
        vecs[6]  = '{8,  8'd13, 7'd21, 3'b000};
        vecs[7]  = '{12, 8'd12, 7'd22, 3'b111};
        vecs[8]  = '{20, 8'd10, 7'd24, 3'b000};
        vecs[9]  = '{22, 8'd12, 7'd24, 3'b111};
        vecs[10] = '{24, 8'd14, 7'd24, 3'b000};

        bus_if.wr_en       = 1'b0;
        bus_if.wr_slot     = '0;
        bus_if.wr_x        = '0;
        bus_if.wr_y        = '0;
        bus_if.wr_glyph    = '0;
        bus_if.wr_fg       = '0;
        bus_if.bg          = 3'b000;
        bus_if.start       = 1'b0;
        bus_if.full_redraw = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("reset_plot", bus_if.plot, 0);
        check("reset_busy", bus_if.busy, 0);
        check("reset_done", bus_if.done, 0);
        check("reset_xy", {bus_if.x, bus_if.y, bus_if.colour}, 0);
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Empty pass: 4 SEEK + FINISH.
        start_pass(1'b0);
        wait_done("empty");
        check("empty_busy_cycles", busy_cycles, 5);
        check("empty_plots", plots.size(), 0);

        // Slot 2 glyph, table-driven pixel checks.
        write_slot(2, 8'd10, 7'd20, 25'b01110_00100_00100_00100_01110, 3'b111);
        start_pass(1'b0);
        wait_done("slot2");
        check("slot2_plots", plots.size(), 25);
        for (int i = 0; i < 11; i++) begin
            p = '{8'hff, 7'h7f, 3'b000};
            if (vecs[i].idx < plots.size()) p = plots[vecs[i].idx];
            check($sformatf("slot2_px%0d_x", vecs[i].idx), p.x, vecs[i].x);
            check($sformatf("slot2_px%0d_y", vecs[i].idx), p.y, vecs[i].y);
            check($sformatf("slot2_px%0d_c", vecs[i].idx), p.c, vecs[i].c);
        end
        start_pass(1'b0);
        wait_done("slot2_again");
        check("slot2_again_plots", plots.size(), 0);

        // Right-edge clipping of slot 0.
        write_slot(0, 8'd157, 7'd0, 25'h1ffffff, 3'b101);
        start_pass(1'b0);
        wait_done("clip");
        check("clip_plots", plots.size(), 15);
        check("clip_busy_cycles", busy_cycles, 30);
        bad = 0;
        offscreen = 0;
        foreach (plots[k]) begin
            if (plots[k].x >= 8'd160) offscreen++;
            if (plots[k].x != 8'(157 + k % 3) || plots[k].y != 7'(k / 3) ||
                plots[k].c != 3'b101) bad++;
        end
        check("clip_offscreen", offscreen, 0);
        check("clip_coord_errors", bad, 0);

        // Write to slot 1 while it is being drawn.
        write_slot(1, 8'd40, 7'd40, 25'h1ffffff, 3'b010);
        start_pass(1'b0);
        wait_plots(5);
        write_slot(1, 8'd40, 7'd40, 25'h1000000, 3'b110);
        wait_done("midwrite");
        check("midwrite_plots", plots.size(), 25);
        bad = 0;
        foreach (plots[k]) if (plots[k].c != 3'b010) bad++;
        check("midwrite_old_colour_errors", bad, 0);
        bus_if.bg = 3'b100;
        start_pass(1'b0);
        wait_done("redraw");
        check("redraw_plots", plots.size(), 25);
        p = '{8'h00, 7'h00, 3'b000};
        if (plots.size() > 1) p = plots[0];
        check("redraw_first_colour", p.c, 3'b110);
        check("redraw_first_x", p.x, 40);
        p = '{8'h00, 7'h00, 3'b000};
        if (plots.size() > 1) p = plots[1];
        check("redraw_second_colour", p.c, 3'b100);
        bus_if.bg = 3'b000;

        // Move slots on-screen, clear dirt, then force a full redraw.
        write_slot(0, 8'd0, 7'd0, 25'h0f0f0f0, 3'b011);
        write_slot(3, 8'd100, 7'd100, 25'h1555555, 3'b001);
        start_pass(1'b0);
        wait_done("prep");
        check("prep_plots", plots.size(), 50);
        start_pass(1'b1);
        repeat (10) tick();
        pulse_start();
        repeat (30) tick();
        pulse_start();
        wait_done("full");
        check("full_plots", plots.size(), 100);
        check("full_busy_cycles", busy_cycles, 105);

        // Asynchronous reset in the middle of DRAW.
        write_slot(2, 8'd10, 7'd20, 25'h1ffffff, 3'b111);
        write_slot(3, 8'd60, 7'd60, 25'h1ffffff, 3'b111);
        start_pass(1'b0);
        wait_plots(3);
        check("pre_reset_plot", bus_if.plot, 1);
        reset = 1'b1;
        #1;
        check("async_reset_plot", bus_if.plot, 0);
        check("async_reset_busy", bus_if.busy, 0);
        check("async_reset_done", bus_if.done, 0);
        check("async_reset_x", bus_if.x, 0);
        tick();
        reset = 1'b0;
        tick();
        start_pass(1'b0);
        wait_done("post_reset");
        check("post_reset_plots", plots.size(), 0);
        check("post_reset_busy_cycles", busy_cycles, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
